// File: rtl/mu0_run_ctrl.sv
// mu0_run_ctrl: sequences the MU0 core for debug. It owns the core's reset and
// clock enable, serves run/step/stop/restart requests, stops on an instruction
// address breakpoint or on Halted, and counts executed instruction fetches.
module mu0_run_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Restart_req,
  input  logic              Run_req,
  input  logic              Step_req,
  input  logic              Stop_req,
  input  logic              Bp_en,
  input  logic [ADDR_W-1:0] Bp_addr,
  input  logic [ADDR_W-1:0] Cpu_addr,
  input  logic              Cpu_fetch,
  input  logic              Cpu_halted,
  output logic              Cpu_reset,
  output logic              Cpu_en,
  output logic [2:0]        State,
  output logic              Bp_hit,
  output logic [CNT_W-1:0]  Instr_count
);

  typedef enum logic [2:0] {
    S_RESET_HOLD = 3'd0,
    S_PAUSED     = 3'd1,
    S_RUN        = 3'd2,
    S_STEP       = 3'd3,
    S_HALTED     = 3'd4
  } state_t;

  localparam int               HOLD_W    = $clog2(RST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_CYCLES - 1);

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              bp_skip;       // suppresses the breakpoint on the first fetch after resume
  logic              step_fetched;  // the single step's fetch has been issued
  logic              bp_cond;
  logic              bp_stop;
  logic              step_done;

  // Next state and core controls; restart overrides everything but Reset
  always_comb begin
    state_nxt = state;
    Cpu_en    = 1'b0;
    Cpu_reset = 1'b0;
    bp_stop   = 1'b0;
    bp_cond   = Bp_en & Cpu_fetch & (Cpu_addr == Bp_addr) & ~bp_skip;
    step_done = step_fetched & Cpu_fetch;
    case (state)
      S_RESET_HOLD: begin
        // enable stays high so the core's synchronous reset is registered
        Cpu_reset = 1'b1;
        Cpu_en    = 1'b1;
        if (hold_cnt == '0) state_nxt = S_PAUSED;
      end
      S_PAUSED: begin
        if (Run_req)       state_nxt = S_RUN;
        else if (Step_req) state_nxt = S_STEP;
      end
      S_RUN: begin
        Cpu_en = 1'b1;
        if (Cpu_halted)    state_nxt = S_HALTED;
        else if (Stop_req) state_nxt = S_PAUSED;
        else if (bp_cond) begin
          // freeze before the matching fetch so the PC stays on the breakpoint
          Cpu_en    = 1'b0;
          bp_stop   = 1'b1;
          state_nxt = S_PAUSED;
        end
      end
      S_STEP: begin
        Cpu_en = 1'b1;
        if (Cpu_halted) state_nxt = S_HALTED;
        else if (step_done) begin
          Cpu_en    = 1'b0;
          state_nxt = S_PAUSED;
        end
      end
      S_HALTED: ;
      default: state_nxt = S_RESET_HOLD;
    endcase
    if (Restart_req) begin
      state_nxt = S_RESET_HOLD;
      bp_stop   = 1'b0;
    end
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_RESET_HOLD;
    else       state <= state_nxt;
  end

  // Reset-hold countdown, reloaded on every reset or restart cycle
  always_ff @(posedge Clk) begin
    if (Reset || Restart_req)                          hold_cnt <= HOLD_INIT;
    else if (state == S_RESET_HOLD && hold_cnt != '0)  hold_cnt <= hold_cnt - 1'b1;
  end

  // Breakpoint skip and single-step fetch tracking
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bp_skip      <= 1'b0;
      step_fetched <= 1'b0;
    end else begin
      if (state == S_PAUSED && (state_nxt == S_RUN || state_nxt == S_STEP))
        bp_skip <= 1'b1;
      else if ((state == S_RUN || state == S_STEP) && Cpu_en && Cpu_fetch)
        bp_skip <= 1'b0;
      step_fetched <= (state == S_STEP) & (step_fetched | (Cpu_en & Cpu_fetch));
    end
  end

  // Breakpoint-hit flag: set when a breakpoint pauses the core, cleared on exit
  always_ff @(posedge Clk) begin
    if (Reset || Restart_req)                      Bp_hit <= 1'b0;
    else if (bp_stop)                              Bp_hit <= 1'b1;
    else if (state == S_PAUSED && state_nxt != S_PAUSED) Bp_hit <= 1'b0;
  end

  // Saturating count of executed instruction fetches
  always_ff @(posedge Clk) begin
    if (Reset || Restart_req)
      Instr_count <= '0;
    else if (Cpu_en && Cpu_fetch && !Cpu_reset && !(&Instr_count))
      Instr_count <= Instr_count + 1'b1;
  end

  assign State = state;

endmodule

// File: tb/tb_mu0_run_ctrl.sv
// Bench for mu0_run_ctrl: a small behavioural MU0 (2-cycle fetch/execute,
// linear program with an STP at a chosen address) is driven by the controller.
// Expected values come from program arithmetic (breakpoint address, STP
// address, number of steps). A second instance with a 4-bit counter shares all
// inputs to exercise saturation.
module tb_mu0_run_ctrl;
  localparam int AW = 12;
  localparam int CW = 16;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1, Restart_req = 1'b0, Run_req = 1'b0, Step_req = 1'b0, Stop_req = 1'b0;
  logic          Bp_en = 1'b0;
  logic [AW-1:0] Bp_addr = '0;
  logic [AW-1:0] Cpu_addr;
  logic          Cpu_fetch, Cpu_halted;
  logic          Cpu_reset, Cpu_en, Bp_hit;
  logic [2:0]    State;
  logic [CW-1:0] Instr_count;
  logic          s_cpu_reset, s_cpu_en, s_bp_hit;
  logic [2:0]    s_state;
  logic [3:0]    s_count;

  int nvec = 0;
  int nerr = 0;

  always #5 Clk = ~Clk;

  mu0_run_ctrl #(.ADDR_W(AW), .CNT_W(CW), .RST_CYCLES(4)) dut (
    .Clk(Clk), .Reset(Reset), .Restart_req(Restart_req), .Run_req(Run_req),
    .Step_req(Step_req), .Stop_req(Stop_req), .Bp_en(Bp_en), .Bp_addr(Bp_addr),
    .Cpu_addr(Cpu_addr), .Cpu_fetch(Cpu_fetch), .Cpu_halted(Cpu_halted),
    .Cpu_reset(Cpu_reset), .Cpu_en(Cpu_en), .State(State), .Bp_hit(Bp_hit),
    .Instr_count(Instr_count));

  mu0_run_ctrl #(.ADDR_W(AW), .CNT_W(4), .RST_CYCLES(4)) dut_sat (
    .Clk(Clk), .Reset(Reset), .Restart_req(Restart_req), .Run_req(Run_req),
    .Step_req(Step_req), .Stop_req(Stop_req), .Bp_en(Bp_en), .Bp_addr(Bp_addr),
    .Cpu_addr(Cpu_addr), .Cpu_fetch(Cpu_fetch), .Cpu_halted(Cpu_halted),
    .Cpu_reset(s_cpu_reset), .Cpu_en(s_cpu_en), .State(s_state), .Bp_hit(s_bp_hit),
    .Instr_count(s_count));

  // Behavioural MU0: fetch phase then execute phase, PC advances on fetch
  logic [AW-1:0] pc = '0;
  logic          phase = 1'b0;
  logic          halted = 1'b0;
  logic          cur_stp = 1'b0;
  logic [AW-1:0] stp_addr = '1;

  assign Cpu_fetch  = !halted && !phase;
  assign Cpu_addr   = phase ? (pc ^ 12'h800) : pc;
  assign Cpu_halted = halted;

  always @(posedge Clk) begin
    if (Cpu_reset && Cpu_en) begin
      pc <= '0; phase <= 1'b0; halted <= 1'b0; cur_stp <= 1'b0;
    end else if (Cpu_en && !halted) begin
      if (!phase) begin
        phase   <= 1'b1;
        cur_stp <= (pc == stp_addr);
        pc      <= pc + 1'b1;
      end else begin
        phase <= 1'b0;
        if (cur_stp) halted <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic wait_paused(input string tag);
    int k = 0;
    while (State !== 3'd1 && k < 200) begin tick(); k++; end
    if (State !== 3'd1) begin
      nvec++; nerr++;
      $display("FAIL %s timeout: State=%0d required 1", tag, State);
    end
  endtask

  task automatic restart();
    Restart_req = 1'b1; tick(); Restart_req = 1'b0;
    wait_paused("restart");
  endtask

  task automatic test_reset();
    int hi = 0;
    Reset = 1'b1;
    repeat (3) tick();
    nvec++; if (State !== 3'd0) begin nerr++; $display("FAIL rst_state: got %0d want 0", State); end
    nvec++; if (Cpu_reset !== 1'b1 || Cpu_en !== 1'b1) begin nerr++; $display("FAIL rst_ctl: reset=%b en=%b want 1 1", Cpu_reset, Cpu_en); end
    nvec++; if (Bp_hit !== 1'b0 || Instr_count !== '0) begin nerr++; $display("FAIL rst_regs: bp=%b cnt=%0d want 0 0", Bp_hit, Instr_count); end
    Reset = 1'b0;
    while (Cpu_reset === 1'b1 && hi < 20) begin tick(); hi++; end
    nvec++; if (hi != 4) begin nerr++; $display("FAIL rst_hold: cycles=%0d want 4", hi); end
    nvec++; if (State !== 3'd1 || Cpu_en !== 1'b0) begin nerr++; $display("FAIL rst_paused: state=%0d en=%b want 1 0", State, Cpu_en); end
    nvec++; if (Instr_count !== '0 || s_count !== 4'd0) begin nerr++; $display("FAIL rst_cnt: %0d/%0d want 0", Instr_count, s_count); end
  endtask

  task automatic test_step();
    int n;
    int exp_cnt = 0;
    restart();
    Bp_en = 1'b0;
    n = $urandom_range(2, 5);
    for (int s = 0; s < n; s++) begin
      logic [AW-1:0] p0;
      int en_f = 0;
      int k = 0;
      repeat ($urandom_range(0, 3)) tick();
      p0 = pc;
      Step_req = 1'b1; tick(); Step_req = 1'b0;
      nvec++; if (State !== 3'd3) begin nerr++; $display("FAIL step_enter: state=%0d want 3", State); end
      while (State === 3'd3 && k < 12) begin
        if (Cpu_fetch && Cpu_en) en_f++;
        tick(); k++;
      end
      exp_cnt++;
      nvec++; if (en_f != 1) begin nerr++; $display("FAIL step_fetches: got %0d want 1", en_f); end
      nvec++; if (State !== 3'd1 || Cpu_en !== 1'b0) begin nerr++; $display("FAIL step_exit: state=%0d en=%b want 1 0", State, Cpu_en); end
      nvec++; if (Instr_count !== CW'(exp_cnt)) begin nerr++; $display("FAIL step_cnt: got %0d want %0d", Instr_count, exp_cnt); end
      nvec++; if (pc !== p0 + 1'b1) begin nerr++; $display("FAIL step_pc: got %0h want %0h", pc, p0 + 1'b1); end
    end
  endtask

  task automatic test_breakpoint();
    for (int it = 0; it < 2; it++) begin
      int a;
      int k = 0;
      a = (it == 0) ? 5 : $urandom_range(3, 9);
      restart();
      Bp_en = 1'b1; Bp_addr = AW'(a);
      Run_req = 1'b1; tick(); Run_req = 1'b0;
      nvec++; if (State !== 3'd2 || Cpu_en !== 1'b1) begin nerr++; $display("FAIL bp_run: state=%0d en=%b want 2 1", State, Cpu_en); end
      while (!(Cpu_fetch && Cpu_addr == AW'(a)) && k < 60) begin tick(); k++; end
      nvec++; if (Cpu_en !== 1'b0) begin nerr++; $display("FAIL bp_en: got %b want 0 at fetch %0h", Cpu_en, Cpu_addr); end
      tick();
      nvec++; if (State !== 3'd1 || Bp_hit !== 1'b1) begin nerr++; $display("FAIL bp_stop: state=%0d bp=%b want 1 1", State, Bp_hit); end
      nvec++; if (Instr_count !== CW'(a) || s_count !== 4'(a)) begin nerr++; $display("FAIL bp_cnt: got %0d/%0d want %0d", Instr_count, s_count, a); end
      nvec++; if (Cpu_addr !== AW'(a) || Cpu_fetch !== 1'b1) begin nerr++; $display("FAIL bp_pc: addr=%0h fetch=%b want %0h 1", Cpu_addr, Cpu_fetch, a); end
      Run_req = 1'b1; tick(); Run_req = 1'b0;
      nvec++; if (Bp_hit !== 1'b0 || Cpu_en !== 1'b1) begin nerr++; $display("FAIL bp_resume: bp=%b en=%b want 0 1", Bp_hit, Cpu_en); end
      repeat (10) tick();
      nvec++; if (State !== 3'd2 || Instr_count !== CW'(a + 5)) begin nerr++; $display("FAIL bp_cont: state=%0d cnt=%0d want 2 %0d", State, Instr_count, a + 5); end
      Stop_req = 1'b1; tick(); Stop_req = 1'b0;
      nvec++; if (State !== 3'd1 || Instr_count !== CW'(a + 6)) begin nerr++; $display("FAIL stop: state=%0d cnt=%0d want 1 %0d", State, Instr_count, a + 6); end
    end
    Bp_en = 1'b0;
  endtask

  task automatic test_stop_vs_bp();
    int a;
    int k = 0;
    a = $urandom_range(2, 9);
    restart();
    Bp_en = 1'b1; Bp_addr = AW'(a);
    Run_req = 1'b1; tick(); Run_req = 1'b0;
    while (!(Cpu_fetch && Cpu_addr == AW'(a)) && k < 60) begin tick(); k++; end
    Stop_req = 1'b1; #1;
    nvec++; if (Cpu_en !== 1'b1) begin nerr++; $display("FAIL stopbp_en: got %b want 1", Cpu_en); end
    tick(); Stop_req = 1'b0;
    nvec++; if (State !== 3'd1 || Bp_hit !== 1'b0) begin nerr++; $display("FAIL stopbp_state: state=%0d bp=%b want 1 0", State, Bp_hit); end
    nvec++; if (Instr_count !== CW'(a + 1)) begin nerr++; $display("FAIL stopbp_cnt: got %0d want %0d", Instr_count, a + 1); end
    Bp_en = 1'b0;
  endtask

  task automatic test_halt();
    int h;
    int k = 0;
    int sat;
    h = $urandom_range(8, 15);
    sat = (h + 1 > 15) ? 15 : h + 1;
    stp_addr = AW'(h);
    Bp_en = 1'b0;
    restart();
    Run_req = 1'b1; tick(); Run_req = 1'b0;
    while (Cpu_halted !== 1'b1 && k < 80) begin tick(); k++; end
    nvec++; if (State !== 3'd2) begin nerr++; $display("FAIL halt_pre: state=%0d want 2", State); end
    tick();
    nvec++; if (State !== 3'd4 || Cpu_en !== 1'b0 || Cpu_reset !== 1'b0) begin nerr++; $display("FAIL halt_state: state=%0d en=%b rst=%b want 4 0 0", State, Cpu_en, Cpu_reset); end
    nvec++; if (Instr_count !== CW'(h + 1) || s_count !== 4'(sat)) begin nerr++; $display("FAIL halt_cnt: got %0d/%0d want %0d/%0d", Instr_count, s_count, h + 1, sat); end
    Run_req = 1'b1; tick(); Run_req = 1'b0;
    Step_req = 1'b1; tick(); Step_req = 1'b0;
    tick();
    nvec++; if (State !== 3'd4 || Cpu_en !== 1'b0) begin nerr++; $display("FAIL halt_ignore: state=%0d en=%b want 4 0", State, Cpu_en); end
    Restart_req = 1'b1; tick(); Restart_req = 1'b0;
    nvec++; if (State !== 3'd0 || Instr_count !== '0 || Cpu_reset !== 1'b1) begin nerr++; $display("FAIL halt_restart: state=%0d cnt=%0d rst=%b want 0 0 1", State, Instr_count, Cpu_reset); end
    wait_paused("halt_restart");
    stp_addr = '1;
  endtask

  task automatic test_saturation();
    int a;
    a = $urandom_range(20, 30);
    restart();
    Bp_en = 1'b1; Bp_addr = AW'(a);
    Run_req = 1'b1; tick(); Run_req = 1'b0;
    wait_paused("sat_run");
    nvec++; if (Instr_count !== CW'(a)) begin nerr++; $display("FAIL sat_wide: got %0d want %0d", Instr_count, a); end
    nvec++; if (s_count !== 4'hF || s_state !== 3'd1) begin nerr++; $display("FAIL sat_narrow: cnt=%0h state=%0d want f 1", s_count, s_state); end
    Bp_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_step();
    test_breakpoint();
    test_stop_vs_bp();
    test_halt();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mu0_run_ctrl.md
# mu0_run_ctrl

Run controller that sequences the MU0 processor for bench and board debug. It owns MU0's reset and clock-enable and accepts run, step, stop and restart requests. It stops the core on an instruction-address breakpoint or on Halted, and counts executed instruction fetches. It sits between the debug/button logic and the MU0 core; the MU0_Memory connection is unchanged.

## Interface
- ADDR_W, 12, width of MU0 address bus
- CNT_W, 16, width of instruction counter
- RST_CYCLES, 4, cycles Cpu_reset is held after controller reset/restart (≥1)

- Clk  in  1  system clock, all state changes on rising edge
- Reset  in  1  synchronous, active-high controller reset
- Restart_req  in  1  pulse: re-reset MU0 and clear counter
- Run_req  in  1  pulse: free-run from PAUSED
- Step_req  in  1  pulse: execute exactly one instruction from PAUSED
- Stop_req  in  1  pulse: pause a free-running core
- Bp_en  in  1  breakpoint enable
- Bp_addr  in  ADDR_W  breakpoint instruction address
- Cpu_addr  in  ADDR_W  MU0 Addr
- Cpu_fetch  in  1  high while MU0 is in its fetch cycle (Cpu_addr = PC)
- Cpu_halted  in  1  MU0 Halted
- Cpu_reset  out  1  reset to MU0
- Cpu_en  out  1  MU0 clock enable (combinational from state + inputs)
- State  out  3  0 RESET_HOLD, 1 PAUSED, 2 RUN, 3 STEP, 4 HALTED
- Bp_hit  out  1  registered, high while PAUSED due to breakpoint
- Instr_count  out  CNT_W  executed fetch count

## Operation
- RESET_HOLD: Cpu_reset=1, Cpu_en=1 (so MU0 synchronous reset registers). Hold counter loads RST_CYCLES-1 on Reset or Restart_req, decrements each cycle; at 0 → PAUSED.
- PAUSED: Cpu_en=0. Run_req → RUN; Step_req → STEP; both together → RUN. Entering RUN/STEP from PAUSED sets bp_skip.
- RUN: Cpu_en=1 unless bp_cond. bp_cond = Bp_en & Cpu_fetch & (Cpu_addr==Bp_addr) & !bp_skip. On bp_cond: Cpu_en=0 that cycle, → PAUSED, Bp_hit←1. Stop_req → PAUSED (Cpu_en stays 1 that cycle). bp_skip clears after the first enabled fetch cycle, so resuming at a breakpoint address executes it.
- STEP: Cpu_en=1 through the first fetch and its execute. The next Cpu_fetch forces Cpu_en=0 that cycle, → PAUSED. Breakpoints are ignored in STEP.
- HALTED: Cpu_en=0, Cpu_reset=0. Exit only via Restart_req or Reset.
- Priority, any state: Reset > Restart_req > Cpu_halted (RUN/STEP → HALTED) > Stop_req > bp_cond > step-complete.
- Instr_count: +1 each cycle with Cpu_en & Cpu_fetch & !Cpu_reset. Saturates at all-ones. Cleared on Reset/Restart_req.
- Bp_hit clears on leaving PAUSED or on restart.
- Run/Step/Stop requests in states where they are not listed are ignored, not queued.

## Timing
- After Reset: State=0, Cpu_reset=1, Cpu_en=1, Bp_hit=0, Instr_count=0.
- Cpu_reset deasserts exactly RST_CYCLES cycles after the last cycle Reset/Restart_req is high. State=PAUSED on the same edge.
- Run_req sampled high at edge N → State=RUN and Cpu_en=1 in cycle N+1.
- Breakpoint: the matching fetch cycle has Cpu_en=0 combinationally. The PC is not advanced, and State=PAUSED from the next edge.
- Step: Cpu_en is high for exactly one fetch+execute sequence. The MU0 fetch/execute is 2 cycles, so Instr_count rises by 1.
- Cpu_halted high in RUN → HALTED next edge. Cpu_en is 0 from then on.
- Restart mid-RUN/STEP: Cpu_reset=1 from the next edge. In-flight instruction is abandoned.

## Test plan
- Reset 3 cycles, RST_CYCLES=4 → Cpu_reset high 4 cycles after Reset falls; State=1, Cpu_en=0, Instr_count=0.
- PAUSED, Step_req pulse → exactly one Cpu_fetch with Cpu_en=1, State 3→1, Instr_count=1, PC advanced by 1.
- Bp_en=1, Bp_addr=0x005, Run_req → stops with Cpu_addr=0x005 fetch and Cpu_en=0, State=1, Bp_hit=1, Instr_count=5. A second Run_req executes 0x005 and continues.
- Program ending in STP, Run_req → Cpu_halted rises, State=4 next edge, Cpu_en=0. Run_req/Step_req ignored. Restart_req → State=0, Instr_count=0.
- RUN with Stop_req and bp_cond in the same cycle → State=1, Bp_hit=0, that cycle's Cpu_en=1 (stop wins).
- Force Instr_count near all-ones (CNT_W=4, 20 fetches) → holds at 0xF.
